// File: rtl/comp_thresh_readback_fsm_pkg.sv
// comp_thresh_readback_fsm_pkg -- state encodings, control bundle and voting/decoding helpers.
// Rev 1.0
`default_nettype none

package comp_thresh_readback_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SELECT = 2'b01,
    ST_DONE   = 2'b10,
    ST_SHIFT  = 2'b11
  } state_t;

  typedef struct packed {
    logic cs_n;
    logic sclk;
    logic busy;
    logic done;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{cs_n: 1'b1, sclk: 1'b0, busy: 1'b0, done: 1'b0};

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // An unknown or corrupted voted state falls through to default and recovers to Idle.
  function automatic state_t next_state(
    input state_t cur,
    input logic   req,
    input logic   start,
    input logic   phase_last,
    input logic   hi,
    input logic   bit_last
  );
    state_t ns;
    case (cur)
      ST_IDLE:   ns = req ? ST_SELECT : ST_IDLE;
      ST_SELECT: ns = phase_last ? ST_SHIFT : ST_SELECT;
      ST_SHIFT:  ns = (phase_last && hi && bit_last) ? ST_DONE : ST_SHIFT;
      ST_DONE:   ns = start ? ST_DONE : ST_IDLE;
      default:   ns = ST_IDLE;
    endcase
    return ns;
  endfunction

  function automatic ctl_t decode_ctl(input state_t ns, input logic hi_next);
    ctl_t c;
    c.busy = (ns == ST_SELECT) || (ns == ST_SHIFT);
    c.cs_n = ~c.busy;
    c.sclk = (ns == ST_SHIFT) && hi_next;
    c.done = (ns == ST_DONE);
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/comp_thresh_readback_fsm_tmr_vote.sv
// comp_thresh_readback_fsm_tmr_vote -- bitwise 2-of-3 majority voter of parameterised width.
// Rev 1.0
`default_nettype none

module comp_thresh_readback_fsm_tmr_vote
  import comp_thresh_readback_fsm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y[i] = maj3(a[i], b[i], c[i]);
  end

endmodule

`default_nettype wire

// File: rtl/comp_thresh_readback_fsm.sv
// comp_thresh_readback_fsm -- TMR serial readback receiver for the comparator-threshold DAC chain.
// Rev 1.0
`default_nettype none

module comp_thresh_readback_fsm
  import comp_thresh_readback_fsm_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sdi,
  output logic             sclk,
  output logic             cs_n,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] dout
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(NBITS);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);

  state_t state_0, state_1, state_2, state_v;
  state_t ns_0, ns_1, ns_2;
  ctl_t   ctl_0, ctl_1, ctl_2, ctl_v;
  ctl_t   ctl_nx_0, ctl_nx_1, ctl_nx_2;
  logic [1:0] state_vote;
  logic [3:0] ctl_vote;

  logic             req;
  logic [PW-1:0]    phase_cnt, phase_nx;
  logic [BW-1:0]    bit_cnt, bit_nx;
  logic             hi, hi_nx;
  logic             capture;
  logic             phase_last, bit_last, enter_done;
  logic [NBITS-1:0] shadow;

  comp_thresh_readback_fsm_tmr_vote #(.WIDTH(2)) u_vote_state (
    .a (state_0),
    .b (state_1),
    .c (state_2),
    .y (state_vote)
  );
  assign state_v = state_t'(state_vote);

  comp_thresh_readback_fsm_tmr_vote #(.WIDTH(4)) u_vote_ctl (
    .a (ctl_0),
    .b (ctl_1),
    .c (ctl_2),
    .y (ctl_vote)
  );
  assign ctl_v = ctl_t'(ctl_vote);

  assign cs_n = ctl_v.cs_n;
  assign sclk = ctl_v.sclk;
  assign busy = ctl_v.busy;
  assign done = ctl_v.done;

  assign phase_last = (phase_cnt == PHASE_LAST);
  assign bit_last   = (bit_cnt == BIT_LAST);
  assign enter_done = (state_v == ST_SHIFT) && phase_last && hi && bit_last;

  // Shift bits split into a low and a high half, DIV cycles each; SDI is taken as SCLK rises.
  always_comb begin
    phase_nx = '0;
    bit_nx   = '0;
    hi_nx    = 1'b0;
    capture  = 1'b0;
    case (state_v)
      ST_SELECT: begin
        phase_nx = phase_last ? '0 : phase_cnt + 1'b1;
      end
      ST_SHIFT: begin
        bit_nx = bit_cnt;
        hi_nx  = hi;
        if (phase_last) begin
          phase_nx = '0;
          if (!hi) begin
            hi_nx   = 1'b1;
            capture = 1'b1;
          end else begin
            hi_nx  = 1'b0;
            bit_nx = bit_last ? bit_cnt : bit_cnt + 1'b1;
          end
        end else begin
          phase_nx = phase_cnt + 1'b1;
        end
      end
      default: begin
        phase_nx = '0;
        bit_nx   = '0;
        hi_nx    = 1'b0;
      end
    endcase
  end

  // Each copy derives its next state and outputs from the voted state independently.
  always_comb begin
    ns_0     = next_state(state_v, req, start, phase_last, hi, bit_last);
    ctl_nx_0 = decode_ctl(ns_0, hi_nx);
  end

  always_comb begin
    ns_1     = next_state(state_v, req, start, phase_last, hi, bit_last);
    ctl_nx_1 = decode_ctl(ns_1, hi_nx);
  end

  always_comb begin
    ns_2     = next_state(state_v, req, start, phase_last, hi, bit_last);
    ctl_nx_2 = decode_ctl(ns_2, hi_nx);
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_0 <= ST_IDLE;
      state_1 <= ST_IDLE;
      state_2 <= ST_IDLE;
      ctl_0   <= CTL_RESET;
      ctl_1   <= CTL_RESET;
      ctl_2   <= CTL_RESET;
    end else begin
      state_0 <= ns_0;
      state_1 <= ns_1;
      state_2 <= ns_2;
      ctl_0   <= ctl_nx_0;
      ctl_1   <= ctl_nx_1;
      ctl_2   <= ctl_nx_2;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req       <= 1'b0;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      hi        <= 1'b0;
      shadow    <= '0;
      dout      <= '0;
    end else begin
      req       <= start;
      phase_cnt <= phase_nx;
      bit_cnt   <= bit_nx;
      hi        <= hi_nx;
      if (capture) begin
        shadow <= {shadow[NBITS-2:0], sdi};
      end
      if (enter_done) begin
        dout <= shadow;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_comp_thresh_readback_fsm.sv
// tb_comp_thresh_readback_fsm -- scoreboard bench with a DAC-chain readback model.
// Rev 1.0
`default_nettype none

module tb_comp_thresh_readback_fsm;
  import comp_thresh_readback_fsm_pkg::*;

  localparam int NBITS     = 16;
  localparam int DIV       = 2;
  localparam int LAST_EDGE = 1 + DIV + 2 * DIV * NBITS;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             sdi   = 1'b0;
  logic             sclk, cs_n, busy, done;
  logic [NBITS-1:0] dout;

  int checks = 0;
  int errors = 0;

  logic [NBITS-1:0] exp_q[$];
  logic [NBITS-1:0] sdi_word = '0;
  int               idx = 0;
  int               rises = 0;
  int               cs_falls = 0;
  logic             done_d = 1'b0;

  comp_thresh_readback_fsm #(.NBITS(NBITS), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sdi   (sdi),
    .sclk  (sclk),
    .cs_n  (cs_n),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  // DAC chain: presents the MSB at select and advances on each SCLK fall.
  always @(negedge cs_n) begin
    cs_falls = cs_falls + 1;
    idx = NBITS - 1;
    sdi = sdi_word[idx];
  end

  always @(negedge sclk) begin
    if (!cs_n && idx > 0) begin
      idx = idx - 1;
      sdi = sdi_word[idx];
    end
  end

  always @(posedge sclk) rises = rises + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (done === 1'b1 && done_d !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected done", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        check("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
    done_d = done;
  end

  // {cs_n, sclk, busy, done} expected after edge e, edge 0 being where START is first sampled.
  function automatic logic [3:0] exp_wave(input int e);
    logic s;
    if (e >= 1 && e < LAST_EDGE) begin
      s = (e >= 1 + DIV) && (((e - 1 - DIV) % (2 * DIV)) >= DIV);
      return {1'b0, s, 1'b1, 1'b0};
    end else if (e == LAST_EDGE) begin
      return 4'b1001;
    end
    return 4'b1000;
  endfunction

  task automatic read_word(input logic [NBITS-1:0] w, input bit pre, input bit pulse,
                           input bit seu, input string tag);
    int r0;
    int last;
    sdi_word = w;
    exp_q.push_back(w);
    if (!pre) begin
      @(posedge clk);
      start = 1'b1;
    end
    r0   = rises;
    last = pulse ? LAST_EDGE + 1 : LAST_EDGE;
    for (int e = 0; e <= last; e++) begin
      @(negedge clk);
      #1;
      check($sformatf("%s wave e%0d", tag, e), 32'({cs_n, sclk, busy, done}), 32'(exp_wave(e)));
      if (pulse && e == 0) begin
        @(posedge clk);
        start = 1'b0;
      end
      if (seu && e == 20) force dut.state_2 = ST_DONE;
      if (seu && e == 21) release dut.state_2;
      if (seu && e == 22) check("seu scrub", 32'(dut.state_2), 32'(ST_SHIFT));
    end
    check({tag, " sclk rises"}, 32'(rises - r0), 32'(NBITS));
  endtask

  initial begin
    int base;
    int held;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ctl", 32'({cs_n, sclk, busy, done}), 32'h8);
    check("reset dout", 32'(dout), 32'h0);
    @(posedge clk);
    rst_n = 1'b1;

    // Abort a transfer with reset in bit 7 of the shift.
    sdi_word = 16'h1234;
    @(posedge clk);
    start = 1'b1;
    repeat (34) @(negedge clk);
    #1;
    check("pre-reset active", 32'({cs_n, busy}), 32'h1);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset ctl", 32'({cs_n, sclk, busy, done}), 32'h8);
    check("async reset dout", 32'(dout), 32'h0);

    // START still high as reset releases: read begins straight away.
    @(posedge clk);
    rst_n = 1'b1;
    base = cs_falls;
    read_word(16'hA5C3, 1'b1, 1'b0, 1'b0, "basic");

    held = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1 && cs_n === 1'b1) held = held + 1;
    end
    check("done held", 32'(held), 32'd100);
    @(posedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    check("release idle", 32'({cs_n, sclk, busy, done}), 32'h8);
    repeat (3) @(negedge clk);
    check("single cs fall", 32'(cs_falls - base), 32'd1);

    read_word(16'h0001, 1'b0, 1'b1, 1'b0, "pulse");

    read_word(16'h5A5A, 1'b0, 1'b0, 1'b1, "seu");
    @(posedge clk);
    start = 1'b0;

    read_word(16'hFFFF, 1'b0, 1'b0, 1'b0, "b2b ffff");
    @(posedge clk);
    start = 1'b0;
    read_word(16'h0000, 1'b0, 1'b0, 1'b0, "b2b 0000");
    @(posedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
